full_adder: RTL and testbench
=============================

# full_adder

Parameterized binary adder with carry-in: adds two WIDTH-bit operands plus a 1-bit carry, producing a WIDTH-bit sum and a carry-out. A combinational result is always available, and a registered copy with a valid flag is provided for pipelined datapaths. With WIDTH = 1 the block is the classic single-bit full adder used as the arithmetic leaf cell throughout the datapath.

## Interface

- WIDTH, default 1, operand and sum width in bits (≥ 1).

- clk  input  1  single clock, rising-edge active.
- rst_n  input  1  reset, synchronous and active-low; one clock.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- c  input  1  carry-in.
- in_valid  input  1  qualifies a/b/c for the registered path.
- sum  output  WIDTH  combinational sum, (a + b + c) mod 2^WIDTH.
- carry  output  1  combinational carry-out, bit WIDTH of a + b + c.
- sum_q  output  WIDTH  registered sum.
- carry_q  output  1  registered carry-out.
- out_valid  output  1  registered in_valid; high when sum_q/carry_q hold a new result.

## Operation

- Combinational path: {carry, sum} = a + b + c, computed at WIDTH+1 bits. It has no state and is not affected by clk or rst_n.
- Structure: a ripple chain of WIDTH 1-bit full-adder cells. Each cell computes s = x ^ y ^ ci and co = (x & y) | (ci & (x ^ y)). Cell 0 takes c. Cell i takes the carry-out of cell i−1. carry is the carry-out of cell WIDTH−1.
- WIDTH = 1 truth table (a b c → sum carry): 000→0 0, 001→1 0, 010→1 0, 011→0 1, 100→1 0, 101→0 1, 110→0 1, 111→1 1.
- Registered path, on each rising clk edge:
  - rst_n = 0: sum_q ← 0, carry_q ← 0, out_valid ← 0.
  - else if in_valid = 1: sum_q ← sum, carry_q ← carry, out_valid ← 1.
  - else: sum_q and carry_q hold their values, out_valid ← 0.
- Operands are unsigned, with no overflow flag. Wrap-around is reported only through carry.
- X/Z on any input propagates. No masking is done.

## Timing

- sum/carry: zero-cycle latency. They settle within one propagation delay after any input change.
- sum_q/carry_q/out_valid: 1-cycle latency. They reflect the inputs sampled at edge N from just after edge N.
- Reset values: sum_q = 0, carry_q = 0, out_valid = 0. Combinational outputs have no reset value and follow the inputs even while rst_n = 0.
- Reset mid-operation: any edge sampled with rst_n = 0 clears the registers, regardless of in_valid. The first result after release appears one edge after the first edge with rst_n = 1 and in_valid = 1.
- Back-to-back in_valid: one result per cycle, with no bubbles.
- Critical path: the ripple carry, WIDTH cells deep. No internal pipelining is allowed, so latency stays fixed at 1.

## Test plan

- WIDTH = 1, exhaustive: apply all 8 (a,b,c) combinations in the order 000…111. Check sum/carry against the truth table after 10 time units, e.g. 011 → sum 0, carry 1 and 111 → sum 1, carry 1.
- WIDTH = 1, registered path: in_valid = 1 with a=1, b=0, c=1. At the next edge sum_q=0, carry_q=1, out_valid=1. Then drop in_valid: out_valid=0 and sum_q/carry_q hold.
- Reset: drive rst_n=0 for 2 edges while in_valid=1 and a=b=c=1. Check sum_q=0, carry_q=0, out_valid=0, while the combinational sum=1 and carry=1. Release, and after one edge sum_q=1, carry_q=1, out_valid=1.
- WIDTH = 8, wrap-around: a=0xFF, b=0x01, c=0 → sum=0x00, carry=1. Also a=0xFF, b=0xFF, c=1 → sum=0xFF, carry=1.
- WIDTH = 8, carry-in only: a=0x00, b=0x00, c=1 → sum=0x01, carry=0. Also a=0x7F, b=0x00, c=1 → sum=0x80, carry=0.
- WIDTH = 8, streaming: random a/b/c with in_valid toggling for 1000 cycles. Scoreboard checks {carry_q, sum_q} = a + b + c from the previous cycle whenever out_valid=1.

Source files
------------

// File: rtl/full_adder.sv
// full_adder
//   Parameterized ripple-carry adder with carry-in. It provides a combinational
//   result and a registered copy that is qualified by a valid flag.
//
// Parameters
//   WIDTH      operand/sum width in bits (>= 1); WIDTH = 1 gives the leaf cell
//
// Ports
//   clk        rising-edge clock for the registered path
//   rst_n      synchronous active-low reset; clears sum_q/carry_q/out_valid
//   a, b       unsigned WIDTH-bit operands
//   c          carry-in
//   in_valid   qualifies a/b/c for capture into the registered path
//   sum        combinational (a + b + c) mod 2^WIDTH
//   carry      combinational carry-out (bit WIDTH of a + b + c)
//   sum_q      registered sum
//   carry_q    registered carry-out
//   out_valid  registered in_valid; high when sum_q/carry_q hold a new result
module full_adder #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic [WIDTH-1:0] sum_q,
    output logic             carry_q,
    output logic             out_valid
);

    // cy[i] is the carry into cell i; cy[WIDTH] is the final carry-out.
    logic [WIDTH:0] cy;

    assign cy[0] = c;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic p;
        assign p         = a[i] ^ b[i];
        assign sum[i]    = p ^ cy[i];
        assign cy[i + 1] = (a[i] & b[i]) | (cy[i] & p);
    end

    assign carry = cy[WIDTH];

    // The registers hold their last result while in_valid is low; only the flag drops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q     <= '0;
            carry_q   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum_q   <= sum;
                carry_q <= carry;
            end
        end
    end

endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder
//   Bench for full_adder. It runs a WIDTH = 1 instance through directed
//   truth-table, registered-path and reset checks. It runs a WIDTH = 8
//   instance through wrap-around and carry-in vectors, then through a
//   randomized stream. The stream is checked by a queue-based scoreboard.
module tb_full_adder;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    // WIDTH = 1 instance
    logic a1, b1, c1, iv1;
    logic sum1, carry1, sum_q1, carry_q1, ov1;

    // WIDTH = 8 instance
    logic [7:0] a8, b8;
    logic       c8, iv8;
    logic [7:0] sum8, sum_q8;
    logic       carry8, carry_q8, ov8;

    full_adder #(.WIDTH(1)) u_fa1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .c(c1), .in_valid(iv1),
        .sum(sum1), .carry(carry1), .sum_q(sum_q1), .carry_q(carry_q1),
        .out_valid(ov1)
    );

    full_adder #(.WIDTH(8)) u_fa8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .c(c8), .in_valid(iv8),
        .sum(sum8), .carry(carry8), .sum_q(sum_q8), .carry_q(carry_q8),
        .out_valid(ov8)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard for the WIDTH = 8 registered path. Each entry is the 9-bit
    // value {carry, sum} expected for an accepted input.
    logic [8:0] sb_q[$];
    logic [8:0] last_exp;
    logic       mon_en = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (ov8) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL w8_unexpected_valid: got out_valid=1 expected no pending result at %0t", $time);
                end else begin
                    last_exp = sb_q.pop_front();
                    check("w8_stream_result", {23'd0, carry_q8, sum_q8}, {23'd0, last_exp});
                end
            end else begin
                check("w8_hold", {23'd0, carry_q8, sum_q8}, {23'd0, last_exp});
            end
        end
    end

    // Spec truth table for WIDTH = 1, indexed by {a,b,c}
    logic tt_sum [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic tt_cry [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    // Directed WIDTH = 8 vectors: a, b, c, expected sum, expected carry
    logic [7:0] v_a [4] = '{8'hFF, 8'hFF, 8'h00, 8'h7F};
    logic [7:0] v_b [4] = '{8'h01, 8'hFF, 8'h00, 8'h00};
    logic       v_c [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [7:0] v_s [4] = '{8'h00, 8'hFF, 8'h01, 8'h80};
    logic       v_k [4] = '{1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        rst_n = 1'b0;
        a1 = 1'b0; b1 = 1'b0; c1 = 1'b0; iv1 = 1'b0;
        a8 = '0;   b8 = '0;   c8 = 1'b0; iv8 = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("w1_reset_sum_q",   {31'd0, sum_q1},   32'd0);
        check("w1_reset_carry_q", {31'd0, carry_q1}, 32'd0);
        check("w1_reset_valid",   {31'd0, ov1},      32'd0);
        check("w8_reset_regs",    {23'd0, carry_q8, sum_q8}, 32'd0);
        check("w8_reset_valid",   {31'd0, ov8},      32'd0);
        rst_n = 1'b1;
        last_exp = '0;
        mon_en = 1'b1;

        // WIDTH = 1 exhaustive combinational check
        for (int i = 0; i < 8; i++) begin
            {a1, b1, c1} = 3'(i);
            #10;
            check($sformatf("w1_sum_%0d", i),   {31'd0, sum1},   {31'd0, tt_sum[i]});
            check($sformatf("w1_carry_%0d", i), {31'd0, carry1}, {31'd0, tt_cry[i]});
        end

        // WIDTH = 1 registered path: capture, then hold
        @(posedge clk); #1;
        a1 = 1'b1; b1 = 1'b0; c1 = 1'b1; iv1 = 1'b1;
        @(posedge clk); #1;
        check("w1_reg_sum_q",   {31'd0, sum_q1},   32'd0);
        check("w1_reg_carry_q", {31'd0, carry_q1}, 32'd1);
        check("w1_reg_valid",   {31'd0, ov1},      32'd1);
        iv1 = 1'b0; a1 = 1'b0; c1 = 1'b0;
        @(posedge clk); #1;
        check("w1_hold_valid",   {31'd0, ov1},      32'd0);
        check("w1_hold_sum_q",   {31'd0, sum_q1},   32'd0);
        check("w1_hold_carry_q", {31'd0, carry_q1}, 32'd1);

        // Reset overrides in_valid; combinational path keeps following inputs
        rst_n = 1'b0; iv1 = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("w1_rst_sum_q",   {31'd0, sum_q1},   32'd0);
        check("w1_rst_carry_q", {31'd0, carry_q1}, 32'd0);
        check("w1_rst_valid",   {31'd0, ov1},      32'd0);
        check("w1_rst_comb_sum",   {31'd0, sum1},   32'd1);
        check("w1_rst_comb_carry", {31'd0, carry1}, 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("w1_post_rst_sum_q",   {31'd0, sum_q1},   32'd1);
        check("w1_post_rst_carry_q", {31'd0, carry_q1}, 32'd1);
        check("w1_post_rst_valid",   {31'd0, ov1},      32'd1);
        iv1 = 1'b0;

        // WIDTH = 8 wrap-around and carry-in vectors
        for (int i = 0; i < 4; i++) begin
            a8 = v_a[i]; b8 = v_b[i]; c8 = v_c[i];
            #10;
            check($sformatf("w8_sum_v%0d", i),   {24'd0, sum8},   {24'd0, v_s[i]});
            check($sformatf("w8_carry_v%0d", i), {31'd0, carry8}, {31'd0, v_k[i]});
        end

        // WIDTH = 8 random stream with in_valid toggling
        @(posedge clk); #1;
        for (int n = 0; n < 1000; n++) begin
            a8  = 8'($urandom);
            b8  = 8'($urandom);
            c8  = 1'($urandom);
            iv8 = 1'($urandom);
            if (iv8)
                sb_q.push_back(9'(int'(a8) + int'(b8) + int'(c8)));
            @(posedge clk); #1;
        end
        iv8 = 1'b0;
        @(posedge clk);
        @(negedge clk); #1;
        check("w8_scoreboard_drained", sb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
